pipe_fetch: RTL and testbench
=============================

PIPE_FETCH -- requirements
Module: pipe_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter QDEPTH, default 2, giving the number of instruction queue entries (legal values 2..4).
REQ-003 The block SHALL have port clk_i, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port imem_req_o, output, 1 bit: instruction memory read request.
REQ-006 The block SHALL have port imem_addr_o, output, 32 bits: read address, meaningful only while imem_req_o=1.
REQ-007 The block SHALL have port imem_rdata_i, input, 32 bits: read data, valid exactly one cycle after the request; memory never back-pressures.
REQ-008 The block SHALL have port redirect_i, input, 1 bit: branch/jump taken, flush and refetch.
REQ-009 The block SHALL have port redirect_pc_i, input, 32 bits: new fetch address, sampled while redirect_i=1.
REQ-010 The block SHALL have port id_ready_i, input, 1 bit: decode stage accepts; 0 means stall.
REQ-011 The block SHALL have port id_valid_o, output, 1 bit: instruction presented to decode.
REQ-012 The block SHALL have port id_instr_o, output, 32 bits: instruction word at the queue head.
REQ-013 The block SHALL have port id_pc_o, output, 32 bits: PC of id_instr_o.

Function
REQ-014 The block SHALL hold a fetch PC register pc_q, a QDEPTH-entry FIFO of {pc, instr} pairs, a FIFO count, and an in-flight flag with its PC.
REQ-015 The block SHALL issue a request (imem_req_o=1, imem_addr_o=pc_q) in any cycle where redirect_i=0 and count + inflight - pop < QDEPTH, where pop = id_valid_o & id_ready_i.
REQ-016 On each issued request, pc_q SHALL advance by 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0), and inflight SHALL set with the issued PC recorded.
REQ-017 A request issued in cycle N SHALL have imem_rdata_i captured into the FIFO tail at the end of cycle N+1; it is visible at id_* in cycle N+2 at the earliest.
REQ-018 id_valid_o SHALL equal (count != 0) & ~redirect_i, and id_instr_o/id_pc_o SHALL show the FIFO head.
REQ-019 A pop SHALL occur only when id_valid_o=1 and id_ready_i=1; a simultaneous push and pop leaves count unchanged.
REQ-020 While id_ready_i=0, id_valid_o, id_instr_o and id_pc_o SHALL hold stable, and the FIFO SHALL never overflow.
REQ-021 With id_ready_i held at 1 and no redirect, steady-state throughput SHALL be one instruction per cycle with consecutive PCs.
REQ-022 On redirect_i=1, at the clock edge: FIFO count cleared, inflight cleared, and pc_q loaded with {redirect_pc_i[31:2], 2'b00}; no request issued and no pop counted in that cycle.
REQ-023 Read data returning in the cycle after a redirect for a pre-redirect request SHALL be discarded.
REQ-024 The first post-redirect request SHALL issue in the cycle following redirect_i=1, to the redirect target.
REQ-025 Back-to-back redirects SHALL each take effect; the last one determines pc_q.
REQ-026 A redirect with a simultaneous push SHALL drop the push.

Reset
REQ-027 While rst_n_i=0, regardless of clock: pc_q=RESET_PC, count=0, inflight=0, imem_req_o=0, id_valid_o=0, id_instr_o=0, id_pc_o=0.
REQ-028 An assertion of rst_n_i mid-operation SHALL discard all queued and in-flight instructions.
REQ-029 In the first cycle after rst_n_i deasserts, the block SHALL issue a request to RESET_PC.

Verification
REQ-030 Reset release, id_ready_i=1, imem returns 32'h1000_0000+addr -> requests at 0,4,8,...; id_valid_o first high 2 cycles after the first request; one instruction per cycle thereafter.
REQ-031 id_ready_i=0 for 5 cycles after the first valid -> id_pc_o holds 0, requests stop after QDEPTH entries are filled/in flight, no data lost; resume yields 4,8,... in order.
REQ-032 redirect_i=1 with redirect_pc_i=32'h0000_0103 while 2 entries queued and 1 in flight -> next request addr 32'h0000_0100; stale data dropped; next id_pc_o=32'h100.
REQ-033 RESET_PC=32'hFFFF_FFF8 -> id_pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-034 rst_n_i pulsed low for half a cycle mid-stream -> outputs go to reset values immediately; fetch restarts at RESET_PC.
REQ-035 Redirects in two consecutive cycles (targets 0x40, then 0x80) -> only 0x80 is fetched; no instruction from 0x40 is ever presented.

Source files
------------

// File: rtl/pipe_fetch.sv
// rtl/pipe_fetch.sv - instruction fetch stage with a small {pc, instr} queue and redirect flush
module pipe_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o
);
    localparam int            PW   = (QDEPTH > 2) ? 2 : 1;
    localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);
    localparam logic [3:0]    QD   = 4'(QDEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   pc_mem    [QDEPTH];
    logic [31:0]   instr_mem [QDEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [2:0]    count_q;
    logic          inflight_q;
    logic [31:0]   inflight_pc_q;
    logic          pop;
    logic          push;
    logic [3:0]    occ;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign id_valid_o  = (count_q != 3'd0) & ~redirect_i;
    assign pop         = id_valid_o & id_ready_i;
    assign push        = inflight_q & ~redirect_i;
    // Occupancy counts the in-flight word so the returning data always has a free slot.
    assign occ         = {1'b0, count_q} + {3'b000, inflight_q} - {3'b000, pop};
    assign imem_req_o  = rst_n_i & ~redirect_i & (occ < QD);
    assign imem_addr_o = pc_q;
    assign id_instr_o  = instr_mem[head_q];
    assign id_pc_o     = pc_mem[head_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q          <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (redirect_i) begin
            // Dropping inflight here also discards the stale word returning next cycle.
            pc_q       <= redirect_pc_i & 32'hFFFF_FFFC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_req_o;
            if (imem_req_o) begin
                pc_q          <= pc_q + 32'd4;
                inflight_pc_q <= pc_q;
            end
            if (push) begin
                pc_mem[tail_q]    <= inflight_pc_q;
                instr_mem[tail_q] <= imem_rdata_i;
                tail_q            <= ptr_next(tail_q);
            end
            if (pop) begin
                head_q <= ptr_next(head_q);
            end
            count_q <= count_q + {2'b00, push} - {2'b00, pop};
        end
    end
endmodule

// File: tb/tb_pipe_fetch.sv
// tb/tb_pipe_fetch.sv - scoreboard bench for pipe_fetch
module tb_pipe_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic [31:0] rdata0, rdata1;
    logic        redirect, redir1;
    logic [31:0] redirect_pc, rpc1;
    logic        ready, ready1;
    logic        valid0, valid1;
    logic [31:0] instr0, instr1, pc0, pc1;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int n1     = 0;
    int p0;
    logic [31:0] exp_q[$];
    logic [31:0] exp1 [4];

    always #5 clk = ~clk;

    pipe_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(3)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .imem_req_o(req0), .imem_addr_o(addr0),
        .imem_rdata_i(rdata0), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .id_ready_i(ready), .id_valid_o(valid0), .id_instr_o(instr0), .id_pc_o(pc0)
    );

    pipe_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .imem_req_o(req1), .imem_addr_o(addr1),
        .imem_rdata_i(rdata1), .redirect_i(redir1), .redirect_pc_i(rpc1),
        .id_ready_i(ready1), .id_valid_o(valid1), .id_instr_o(instr1), .id_pc_o(pc1)
    );

    // Memory model: data = 0x1000_0000 + address, one cycle after the request.
    always @(posedge clk) begin
        rdata0 <= req0 ? 32'h1000_0000 + addr0 : 32'hDEAD_BEEF;
        rdata1 <= req1 ? 32'h1000_0000 + addr1 : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic sb_load(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Sample late in the low phase, after the main sequence has driven this cycle's inputs.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (valid0 && ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", pc0, e);
                    check("sb_instr", instr0, 32'h1000_0000 + e);
                end
            end
            if (valid1 && ready1 && n1 < 4) begin
                check("wrap_pc", pc1, exp1[n1]);
                check("wrap_instr", instr1, 32'h1000_0000 + exp1[n1]);
                n1++;
            end
        end
    end

    initial begin
        exp1 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        ready1 = 1'b1; redir1 = 1'b0; rpc1 = '0;
        repeat (3) tick();
        check("rst_req", {31'd0, req0}, 32'd0);
        check("rst_valid", {31'd0, valid0}, 32'd0);
        check("rst_pc", pc0, 32'd0);
        check("rst_instr", instr0, 32'd0);
        check("rst_pc1", pc1, 32'd0);

        sb_load(32'd0);
        rst_n = 1'b1;
        #1;
        check("first_req", {31'd0, req0}, 32'd1);
        check("first_addr", addr0, 32'd0);
        tick();
        check("lat_valid", {31'd0, valid0}, 32'd0);
        tick();
        check("first_valid", {31'd0, valid0}, 32'd1);
        check("first_pc", pc0, 32'd0);

        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {31'd0, valid0}, 32'd1);
            check("stall_pc", pc0, 32'd0);
            check("stall_req", {31'd0, req0}, 32'd0);
        end
        ready = 1'b1;
        p0 = pops;
        repeat (8) tick();
        check("throughput", 32'(pops - p0), 32'd8);

        // Steady state here is two queued entries with one request in flight.
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        sb_load(32'h0000_0100);
        #1;
        check("redir_req", {31'd0, req0}, 32'd0);
        check("redir_valid", {31'd0, valid0}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("redir_reqhi", {31'd0, req0}, 32'd1);
        check("redir_addr", addr0, 32'h0000_0100);
        check("redir_flush", {31'd0, valid0}, 32'd0);
        tick();
        check("stale_drop", {31'd0, valid0}, 32'd0);
        tick();
        check("redir_vhi", {31'd0, valid0}, 32'd1);
        check("redir_pc", pc0, 32'h0000_0100);
        repeat (4) tick();

        redirect = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        redirect_pc = 32'h0000_0080;
        sb_load(32'h0000_0080);
        tick();
        redirect = 1'b0;
        #1;
        check("b2b_addr", addr0, 32'h0000_0080);
        p0 = pops;
        repeat (6) tick();
        check("b2b_pops", 32'(pops - p0), 32'd4);

        rst_n = 1'b0;
        sb_load(32'd0);
        #1;
        check("ar_valid", {31'd0, valid0}, 32'd0);
        check("ar_req", {31'd0, req0}, 32'd0);
        check("ar_pc", pc0, 32'd0);
        check("ar_instr", instr0, 32'd0);
        #4;
        rst_n = 1'b1;
        #1;
        check("restart_req", {31'd0, req0}, 32'd1);
        check("restart_addr", addr0, 32'd0);
        p0 = pops;
        repeat (6) tick();
        check("restart_pops", 32'(pops - p0), 32'd3);
        check("wrap_count", 32'(n1), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
